// File: rtl/std_rstseq_pkg.sv
// std_rstseq_pkg: shared types for the reset sequencer.
// Phase codes and small elaboration-time helpers.
package std_rstseq_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2,
    RUN  = 2'd3
  } phase_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/std_sync.sv
// std_sync: SYNC-stage flop chain with async active-low clear.
// Output is 0 while nreset is low and for SYNC edges after.
module std_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] chain_q;
  logic [SYNC-1:0] chain_d;

  // shift d in at the bottom of the chain
  always_comb begin
    chain_d = {chain_q[SYNC-2:0], d};
  end

  // chain register, cleared asynchronously
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC-1];

endmodule

// File: rtl/std_rstseq.sv
// std_rstseq: reset sequencer releasing N active-low resets
// one at a time after a synchronised release and hold period.
module std_rstseq #(
  parameter int N    = 4,
  parameter int SYNC = 2,
  parameter int HOLD = 8,
  parameter int GAP  = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         soft_req,
  output logic [N-1:0] nrst_out,
  output logic         done,
  output logic [1:0]   phase
);
  import std_rstseq_pkg::*;

  localparam phase_t P_SYNC = std_rstseq_pkg::SYNC;
  localparam phase_t P_HOLD = std_rstseq_pkg::HOLD;
  localparam phase_t P_REL  = std_rstseq_pkg::REL;
  localparam phase_t P_RUN  = std_rstseq_pkg::RUN;

  localparam int CW = $clog2(imax(HOLD, GAP) + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // reject illegal parameter sets at elaboration
  initial begin
    if (N < 1)    $fatal(1, "std_rstseq: N must be >= 1");
    if (SYNC < 2) $fatal(1, "std_rstseq: SYNC must be >= 2");
    if (HOLD < 1) $fatal(1, "std_rstseq: HOLD must be >= 1");
    if (GAP < 1)  $fatal(1, "std_rstseq: GAP must be >= 1");
  end

  logic          rst_s;
  logic          soft_s;
  phase_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  nrst_q, nrst_d;
  logic          done_q, done_d;

  std_sync #(.SYNC(SYNC)) u_rst_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (1'b1),
    .q      (rst_s)
  );

  std_sync #(.SYNC(SYNC)) u_soft_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (soft_req),
    .q      (soft_s)
  );

  // next state; the counter runs 1..limit so the
  // SYNC->HOLD edge is the first counted hold cycle,
  // while a soft request parks it at 0 one extra edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nrst_d  = nrst_q;
    done_d  = done_q;
    if (soft_s) begin
      state_d = P_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      nrst_d  = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        P_SYNC: begin
          if (rst_s) begin
            state_d = P_HOLD;
            cnt_d   = CNT_ONE;
          end
        end
        P_HOLD: begin
          if (cnt_q == HOLD_END) begin
            nrst_d[0] = 1'b1;
            idx_d     = '0;
            cnt_d     = CNT_ONE;
            state_d   = (N == 1) ? P_RUN : P_REL;
            done_d    = (N == 1);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        P_REL: begin
          if (cnt_q == GAP_END) begin
            cnt_d = CNT_ONE;
            if (int'(idx_q) < N - 1) begin
              idx_d = idx_q + IW'(1);
            end
            for (int i = 1; i < N; i++) begin
              if (i == int'(idx_q) + 1) begin
                nrst_d[i] = 1'b1;
              end
            end
            if (int'(idx_q) + 2 >= N) begin
              state_d = P_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        P_RUN: begin
        end
        default: begin
        end
      endcase
    end
  end

  // state and output registers, all cleared by nreset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= P_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      nrst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
    end
  end

  assign nrst_out = nrst_q;
  assign done     = done_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_std_rstseq.sv
// tb_std_rstseq: randomized and directed checks of std_rstseq
// against an edge-number model of release times.
module tb_std_rstseq;
  import std_rstseq_pkg::*;

  localparam int TN   = 4;
  localparam int TS   = 2;
  localparam int TH   = 8;
  localparam int TG   = 4;
  localparam int KMAX = 2048;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          soft_req = 1'b0;
  logic          nreset1 = 1'b0;
  logic [TN-1:0] nrst_out;
  logic          done;
  logic [1:0]    phase;
  logic [0:0]    nrst_out1;
  logic          done1;
  logic [1:0]    phase1;

  int vec = 0;
  int miss = 0;
  int k = 0;
  int lb = TS;
  logic hist [0:KMAX-1];

  always #5 clk = ~clk;

  std_rstseq #(.N(TN), .SYNC(TS), .HOLD(TH), .GAP(TG)) u_dut (
    .clk      (clk),
    .nreset   (nreset),
    .soft_req (soft_req),
    .nrst_out (nrst_out),
    .done     (done),
    .phase    (phase)
  );

  std_rstseq #(.N(1), .SYNC(3), .HOLD(1), .GAP(1)) u_dut1 (
    .clk      (clk),
    .nreset   (nreset1),
    .soft_req (1'b0),
    .nrst_out (nrst_out1),
    .done     (done1),
    .phase    (phase1)
  );

  // edge at which bit i is released, given the last blocking edge
  function automatic int rel_edge(int lbv, int hold, int gap, int i);
    return lbv + 1 + hold + i * gap;
  endfunction

  function automatic logic [TN-1:0] exp_bits(int kk, int lbv);
    logic [TN-1:0] b;
    b = '0;
    for (int i = 0; i < TN; i++) b[i] = (kk >= rel_edge(lbv, TH, TG, i));
    return b;
  endfunction

  function automatic phase_t exp_phase(int kk, int lbv, int n,
                                       int sync, int hold, int gap);
    if (kk <= sync) return SYNC;
    if (kk < rel_edge(lbv, hold, gap, 0)) return HOLD;
    if (kk >= rel_edge(lbv, hold, gap, n - 1)) return RUN;
    return REL;
  endfunction

  task automatic step();
    logic [TN-1:0] eb;
    phase_t ep;
    @(posedge clk);
    k++;
    if (k < KMAX) hist[k] = soft_req;
    if (k > TS && k - TS < KMAX && hist[k-TS]) lb = k;
    #1;
    eb = exp_bits(k, lb);
    ep = exp_phase(k, lb, TN, TS, TH, TG);
    vec++;
    if (nrst_out !== eb) begin
      miss++;
      $display("FAIL nrst_out edge %0d: got %b want %b", k, nrst_out, eb);
    end
    vec++;
    if (done !== (&eb)) begin
      miss++;
      $display("FAIL done edge %0d: got %b want %b", k, done, &eb);
    end
    vec++;
    if (phase !== ep) begin
      miss++;
      $display("FAIL phase edge %0d: got %0d want %0d", k, phase, ep);
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(string tag);
    vec++;
    if (nrst_out !== '0) begin
      miss++;
      $display("FAIL %s nrst_out: got %b want 0", tag, nrst_out);
    end
    vec++;
    if (done !== 1'b0) begin
      miss++;
      $display("FAIL %s done: got %b want 0", tag, done);
    end
    vec++;
    if (phase !== SYNC) begin
      miss++;
      $display("FAIL %s phase: got %0d want %0d", tag, phase, SYNC);
    end
  endtask

  task automatic release_rst();
    nreset = 1'b1;
    k = 0;
    lb = TS;
    for (int i = 0; i < KMAX; i++) hist[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    soft_req = 1'b0;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic test_reset();
    #1;
    check_cleared("por");
    vec++;
    if (nrst_out1 !== 1'b0 || done1 !== 1'b0 || phase1 !== SYNC) begin
      miss++;
      $display("FAIL por_n1: got %b/%b/%0d want 0/0/0",
               nrst_out1, done1, phase1);
    end
  endtask

  task automatic test_power_on();
    do_reset();
    while (k < 30) step();
  endtask

  task automatic test_async_reset();
    #2;
    nreset = 1'b0;
    #1;
    check_cleared("async");
    @(negedge clk);
    release_rst();
    while (k < 30) step();
  endtask

  task automatic test_soft_run();
    do_reset();
    while (k < 29) step();
    soft_req = 1'b1;
    while (k < 39) step();
    soft_req = 1'b0;
    while (k < 70) step();
  endtask

  task automatic test_soft_rel();
    do_reset();
    while (k < 15) step();
    soft_req = 1'b1;
    while (k < 17) step();
    soft_req = 1'b0;
    while (k < 50) step();
  endtask

  task automatic test_rehold();
    do_reset();
    while (k < 29) step();
    soft_req = 1'b1;
    while (k < 31) step();
    soft_req = 1'b0;
    while (k < 35) step();
    soft_req = 1'b1;
    while (k < 37) step();
    soft_req = 1'b0;
    while (k < 70) step();
  endtask

  task automatic test_random();
    int left;
    left = 0;
    do_reset();
    for (int n = 0; n < 700; n++) begin
      if (left == 0) begin
        soft_req = ($urandom_range(0, 3) == 0);
        left = soft_req ? int'($urandom_range(2, 6))
                        : int'($urandom_range(1, 40));
      end
      left--;
      step();
    end
    soft_req = 1'b0;
    repeat (40) step();
  endtask

  task automatic test_n1();
    int k1;
    phase_t ep;
    logic eb;
    @(negedge clk);
    nreset1 = 1'b1;
    k1 = 0;
    repeat (8) begin
      @(posedge clk);
      k1++;
      #1;
      eb = (k1 >= rel_edge(3, 1, 1, 0));
      ep = exp_phase(k1, 3, 1, 3, 1, 1);
      vec++;
      if (nrst_out1 !== eb || done1 !== eb) begin
        miss++;
        $display("FAIL n1 out edge %0d: got %b/%b want %b",
                 k1, nrst_out1, done1, eb);
      end
      vec++;
      if (phase1 !== ep) begin
        miss++;
        $display("FAIL n1 phase edge %0d: got %0d want %0d",
                 k1, phase1, ep);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < KMAX; i++) hist[i] = 1'b0;
    test_reset();
    test_power_on();
    test_async_reset();
    test_soft_run();
    test_soft_rel();
    test_rehold();
    test_random();
    test_n1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
